// File: rtl/mux_pkg.sv
// Shared constants and FSM encoding for the 16:1 mux deserializer.
package mux_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 4;
  localparam int CNT_W     = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/demux_1to16_reg.sv
// Registered 1:WIDTH demux: each strobed bit lands at its sel position.
module demux_1to16_reg #(
  parameter int WIDTH = mux_pkg::WIDTH_DEF,
  parameter int SEL_W = mux_pkg::SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] dmx_out
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmx_out <= '0;
    end else if (bit_valid) begin
      dmx_out[sel_in] <= bit_in;
    end
  end
endmodule

// File: rtl/mux_deser_16to1.sv
// Reassembles a serialized word from sel-tagged bits; checks scan order.
module mux_deser_16to1
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bit_in,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] dmx_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             seq_err,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] word_d;
  logic [CNT_W-1:0] cnt_d;
  logic             wv_d, err_d;

  demux_1to16_reg #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dmx (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (bit_valid),
    .sel_in    (sel_in),
    .bit_in    (bit_in),
    .dmx_out   (dmx_out)
  );

  assign busy = (state_q == COLLECT);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    word_d   = word_out;
    cnt_d    = word_cnt;
    wv_d     = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      exp_d   = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sel_in == '0) begin
            shadow_d[0] = bit_in;
            exp_d       = SEL_W'(1);
            state_d     = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
        COLLECT: begin
          if (sel_in == exp_q) begin
            shadow_d[sel_in] = bit_in;
            exp_d            = exp_q + SEL_W'(1);
            if (sel_in == LAST) begin
              word_d  = shadow_d;
              wv_d    = 1'b1;
              cnt_d   = word_cnt + CNT_W'(1);
              state_d = IDLE;
            end
          end else begin
            // Out-of-order bit; a fresh sel 0 restarts rather than idling.
            err_d = 1'b1;
            if (sel_in == '0) begin
              shadow_d[0] = bit_in;
              exp_d       = SEL_W'(1);
            end else begin
              exp_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      shadow_q   <= '0;
      word_out   <= '0;
      word_cnt   <= '0;
      word_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      shadow_q   <= shadow_d;
      word_out   <= word_d;
      word_cnt   <= cnt_d;
      word_valid <= wv_d;
      seq_err    <= err_d;
    end
  end
endmodule

// File: tb/tb_mux_deser_16to1.sv
// Directed bench for mux_deser_16to1 with hand-computed expectations.
module tb_mux_deser_16to1;
  logic        clk = 1'b0;
  logic        rst_n, clear, bit_in, bit_valid;
  logic [3:0]  sel_in;
  logic [15:0] dmx_out, word_out;
  logic        word_valid, seq_err, busy;
  logic [7:0]  word_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wv_cyc = 0;
  int first_wv_cyc = 0;

  mux_deser_16to1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_in     (bit_in),
    .sel_in     (sel_in),
    .bit_valid  (bit_valid),
    .dmx_out    (dmx_out),
    .word_out   (word_out),
    .word_valid (word_valid),
    .seq_err    (seq_err),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Sends sel lo..hi of word w; maxgap > 0 inserts random idle cycles.
  task automatic scan(input logic [15:0] w, input int lo, input int hi, input int maxgap);
    for (int i = lo; i <= hi; i++) begin
      bit_valid = 1'b1;
      sel_in    = i[3:0];
      bit_in    = w[i];
      tick();
      chk("no_seq_err", {31'b0, seq_err}, 32'd0);
      if (i == 15) begin
        chk("wv_after_last", {31'b0, word_valid}, 32'd1);
        chk("idle_after_last", {31'b0, busy}, 32'd0);
        wv_cyc = cyc;
      end else begin
        chk("busy_mid", {31'b0, busy}, 32'd1);
        chk("wv_mid", {31'b0, word_valid}, 32'd0);
      end
      bit_valid = 1'b0;
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        for (int k = 0; k < g; k++) begin
          tick();
          if (i != 15) chk("busy_gap", {31'b0, busy}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sel_in = '0;
    tick(); tick();
    chk("rst_dmx",  {16'b0, dmx_out},  32'h0);
    chk("rst_word", {16'b0, word_out}, 32'h0);
    chk("rst_wv",   {31'b0, word_valid}, 32'd0);
    chk("rst_err",  {31'b0, seq_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cnt",  {24'b0, word_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain scan
    scan(16'hC3B4, 0, 15, 0);
    chk("word_c3b4", {16'b0, word_out}, 32'hC3B4);
    chk("cnt_1", {24'b0, word_cnt}, 32'd1);
    idle(1);
    chk("wv_one_cycle", {31'b0, word_valid}, 32'd0);

    // Scan with gaps
    scan(16'hC3BF, 0, 15, 3);
    chk("word_c3bf", {16'b0, word_out}, 32'hC3BF);
    chk("dmx_c3bf", {16'b0, dmx_out}, 32'hC3BF);
    chk("cnt_2", {24'b0, word_cnt}, 32'd2);
    idle(2);

    // Back-to-back words
    scan(16'hC3FF, 0, 15, 0);
    first_wv_cyc = wv_cyc;
    chk("word_c3ff", {16'b0, word_out}, 32'hC3FF);
    bit_valid = 1'b1; sel_in = 4'd0; bit_in = 1'b1;
    tick();
    chk("b2b_wv_drop", {31'b0, word_valid}, 32'd0);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    scan(16'hCFFF, 1, 15, 0);
    chk("word_cfff", {16'b0, word_out}, 32'hCFFF);
    chk("b2b_spacing", wv_cyc - first_wv_cyc, 32'd16);
    chk("cnt_4", {24'b0, word_cnt}, 32'd4);
    idle(1);

    // Skip from 6 to 9
    scan(16'hFFFF, 0, 6, 0);
    bit_valid = 1'b1; sel_in = 4'd9; bit_in = 1'b1;
    tick();
    chk("skip_err", {31'b0, seq_err}, 32'd1);
    chk("skip_busy", {31'b0, busy}, 32'd0);
    chk("skip_word_hold", {16'b0, word_out}, 32'hCFFF);
    idle(1);
    chk("skip_err_pulse", {31'b0, seq_err}, 32'd0);
    scan(16'h1234, 0, 15, 0);
    chk("word_1234", {16'b0, word_out}, 32'h1234);
    idle(1);

    // Non-zero sel while idle
    bit_valid = 1'b1; sel_in = 4'd5; bit_in = 1'b0;
    tick();
    chk("idle_err", {31'b0, seq_err}, 32'd1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    idle(1);

    // Restart on sel 0 mid-word
    scan(16'h0000, 0, 7, 0);
    bit_valid = 1'b1; sel_in = 4'd0; bit_in = 1'b1;
    tick();
    chk("restart_err", {31'b0, seq_err}, 32'd1);
    chk("restart_busy", {31'b0, busy}, 32'd1);
    scan(16'hA5A5, 1, 15, 0);
    chk("word_a5a5", {16'b0, word_out}, 32'hA5A5);
    chk("cnt_6", {24'b0, word_cnt}, 32'd6);
    idle(1);

    // clear wins over a valid bit
    scan(16'hFFFF, 0, 9, 0);
    bit_valid = 1'b1; sel_in = 4'd10; bit_in = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_wv", {31'b0, word_valid}, 32'd0);
    chk("clr_err", {31'b0, seq_err}, 32'd0);
    chk("clr_cnt", {24'b0, word_cnt}, 32'd6);
    chk("clr_word", {16'b0, word_out}, 32'hA5A5);
    sel_in = 4'd11;
    tick();
    chk("post_clr_err", {31'b0, seq_err}, 32'd1);
    chk("dmx_afff", {16'b0, dmx_out}, 32'hAFFF);
    idle(1);

    // Asynchronous reset mid-word
    scan(16'hFFFF, 0, 4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dmx",  {16'b0, dmx_out},  32'h0);
    chk("arst_word", {16'b0, word_out}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_cnt",  {24'b0, word_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle(1);
    chk("arst_no_wv", {31'b0, word_valid}, 32'd0);
    scan(16'h5A5A, 0, 15, 0);
    chk("word_5a5a", {16'b0, word_out}, 32'h5A5A);
    chk("cnt_after_rst", {24'b0, word_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
